// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Requester-side handshake bundle of the shared UART transmitter arbiter.
//
// Signals:
//   req       level request per requester, held until its gnt pulse
//   req_data  byte of requester i at [8i+7:8i], valid while req[i]
//   gnt       1-cycle pulse: requester's byte has been latched
//   done      1-cycle pulse: requester's frame has finished on the line
//
// Modports:
//   master  requester side (drives req/req_data)
//   slave   arbiter side (drives gnt/done)
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;

    modport master (
        output req,
        output req_data,
        input  gnt,
        input  done
    );

    modport slave (
        input  req,
        input  req_data,
        output gnt,
        output done
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ requesters. Round-robin grant,
// byte hand-off to the UART, tx_enable/tx_done sequencing and a baud-select
// register whose updates only take effect between frames.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req_bus           requester handshake (req/req_data in, gnt/done out)
//   baud_wr/wdata     baud-select write strobe and value (any state)
//   uart_data_in      byte presented to the UART, stable from gnt to next gnt
//   uart_tx_enable    start request to the UART
//   uart_baud_select  baud divider to the UART
//   uart_tx_done      UART frame-complete flag
//   busy              high in every state except IDLE
//   owner             index of current / last granted requester
//   err_clr           clears timeout_err
//   timeout_err       sticky frame-timeout flag
//
// Optional feature: define UART_ARB_TIMEOUT_EN to add a per-frame cycle
// counter that abandons a frame after TIMEOUT_CYCLES clocks. Without it the
// FSM waits on the UART indefinitely and timeout_err is tied low.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int         NUM_REQ        = 4,
    parameter logic [7:0] BAUD_RST       = 8'd16,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  req_bus,
    input  logic              baud_wr,
    input  logic [7:0]        baud_wdata,
    output logic [7:0]        uart_data_in,
    output logic              uart_tx_enable,
    output logic [7:0]        uart_baud_select,
    input  logic              uart_tx_done,
    output logic              busy,
    output logic [2:0]        owner,
    input  logic              err_clr,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        RELEASE
    } state_t;

    localparam logic [3:0] NUM_REQ_W = 4'(NUM_REQ);

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    logic [NUM_REQ-1:0] done_reg, done_next;
    logic               tx_en_reg, tx_en_next;
    logic [7:0]         data_reg, data_next;
    logic [7:0]         baud_sel_reg, baud_sel_next;
    logic [7:0]         baud_shadow_reg, baud_shadow_next;
    logic               baud_pend_reg, baud_pend_next;
    logic [2:0]         owner_reg, owner_next;
    logic [2:0]         rr_last_reg, rr_last_next;

    logic               tmo_hit;    // frame budget exhausted this cycle
    logic               tmo_fire;   // FSM actually abandons the frame

    logic [NUM_REQ-1:0] req_vec;
    logic [7:0]         req_byte [NUM_REQ];
    logic [NUM_REQ-1:0] winner_oh;
    logic [NUM_REQ-1:0] owner_oh;
    logic [7:0]         winner_byte;
    logic [7:0]         req_ext;
    logic [3:0]         scan_idx;
    logic               found;
    logic [2:0]         winner;

    assign req_vec = req_bus.req;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_byte[gi]  = req_bus.req_data[8*gi +: 8];
            assign winner_oh[gi] = (winner == 3'(gi));
            assign owner_oh[gi]  = (owner_reg == 3'(gi));
        end
    endgenerate

    // Round-robin scan starting just after the last winner. The index is
    // kept in range with a single conditional subtract instead of a modulo.
    always_comb begin
        req_ext  = 8'(req_vec);
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            scan_idx = {1'b0, rr_last_reg} + 4'(off);
            if (scan_idx >= NUM_REQ_W) begin
                scan_idx = scan_idx - NUM_REQ_W;
            end
            if (!found && req_ext[scan_idx[2:0]]) begin
                found  = 1'b1;
                winner = scan_idx[2:0];
            end
        end
    end

    always_comb begin
        winner_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner_oh[i]) begin
                winner_byte = winner_byte | req_byte[i];
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_next       = state_reg;
        gnt_next         = '0;
        done_next        = '0;
        tx_en_next       = tx_en_reg;
        data_next        = data_reg;
        baud_sel_next    = baud_sel_reg;
        baud_shadow_next = baud_shadow_reg;
        baud_pend_next   = baud_pend_reg;
        owner_next       = owner_reg;
        rr_last_next     = rr_last_reg;
        tmo_fire         = 1'b0;

        // A write is always captured; it only reaches the UART from IDLE.
        if (baud_wr) begin
            baud_shadow_next = baud_wdata;
            baud_pend_next   = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (baud_pend_reg) begin
                    // Apply the old shadow; a write in this same cycle
                    // stays pending for the next IDLE cycle.
                    baud_sel_next = baud_shadow_reg;
                    if (!baud_wr) begin
                        baud_pend_next = 1'b0;
                    end
                end else if (found) begin
                    owner_next   = winner;
                    rr_last_next = winner;
                    data_next    = winner_byte;
                    gnt_next     = winner_oh;
                    state_next   = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_en_next = 1'b1;
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (uart_tx_done) begin
                    tx_en_next = 1'b0;
                    done_next  = owner_oh;
                    state_next = RELEASE;
                end else if (tmo_hit) begin
                    tx_en_next = 1'b0;
                    tmo_fire   = 1'b1;
                    state_next = IDLE;
                end
            end
            RELEASE: begin
                // No new grant until the UART has cleared tx_done.
                if (!uart_tx_done) begin
                    state_next = IDLE;
                end else if (tmo_hit) begin
                    tmo_fire   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            gnt_reg         <= '0;
            done_reg        <= '0;
            tx_en_reg       <= 1'b0;
            data_reg        <= '0;
            baud_sel_reg    <= BAUD_RST;
            baud_shadow_reg <= BAUD_RST;
            baud_pend_reg   <= 1'b0;
            owner_reg       <= '0;
            rr_last_reg     <= 3'(NUM_REQ - 1);
        end else begin
            state_reg       <= state_next;
            gnt_reg         <= gnt_next;
            done_reg        <= done_next;
            tx_en_reg       <= tx_en_next;
            data_reg        <= data_next;
            baud_sel_reg    <= baud_sel_next;
            baud_shadow_reg <= baud_shadow_next;
            baud_pend_reg   <= baud_pend_next;
            owner_reg       <= owner_next;
            rr_last_reg     <= rr_last_next;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [12:0] TMO_LAST = 13'(TIMEOUT_CYCLES - 1);

    logic [12:0] tmo_cnt_reg, tmo_cnt_next;
    logic        tmo_err_reg, tmo_err_next;

    assign tmo_hit = ((state_reg == WAIT_DONE) || (state_reg == RELEASE))
                     && (tmo_cnt_reg == TMO_LAST);

    always_comb begin
        tmo_cnt_next = tmo_cnt_reg;
        tmo_err_next = tmo_err_reg;
        if (state_reg == LAUNCH) begin
            tmo_cnt_next = '0;
        end else if ((state_reg == WAIT_DONE) || (state_reg == RELEASE)) begin
            tmo_cnt_next = tmo_cnt_reg + 13'd1;
        end
        // A fresh timeout beats a simultaneous clear.
        if (tmo_fire) begin
            tmo_err_next = 1'b1;
        end else if (err_clr) begin
            tmo_err_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_reg <= '0;
            tmo_err_reg <= 1'b0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_next;
            tmo_err_reg <= tmo_err_next;
        end
    end

    assign timeout_err = tmo_err_reg;
`else
    logic unused_ok;

    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_ok   = err_clr & tmo_fire & (TIMEOUT_CYCLES != 0);
`endif

    assign req_bus.gnt      = gnt_reg;
    assign req_bus.done     = done_reg;
    assign uart_data_in     = data_reg;
    assign uart_tx_enable   = tx_en_reg;
    assign uart_baud_select = baud_sel_reg;
    assign owner            = owner_reg;
    assign busy             = (state_reg != IDLE);

endmodule
